// File: rtl/pulse_meter.sv
// pulse_meter: measures high-pulse widths on 'in' and hands {ovf,data} over a dav_/rfd handshake
module pulse_meter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in,
  input  logic         rfd,
  output logic [W-1:0] data,
  output logic         ovf,
  output logic         dav_,
  output logic         lost
);
  typedef enum logic [1:0] {ARM, IDLE, CNT} m_state_t;
  typedef enum logic {OIDLE, OWAIT} o_state_t;
  m_state_t       m_q, m_d;
  o_state_t       o_q, o_d;
  logic [W-1:0]   len_q, len_d, buf_len_q, buf_len_d, data_q, data_d;
  logic           sat_q, sat_d, buf_sat_q, buf_sat_d, buf_full_q, buf_full_d;
  logic           ovf_q, ovf_d, lost_q, lost_d;
  logic           done, rel, load, offer;
  always_comb begin
    m_d   = m_q;
    len_d = len_q;
    sat_d = sat_q;
    done  = 1'b0;
    case (m_q)
      ARM:  m_d = in ? ARM : IDLE;
      IDLE: if (in) begin
        m_d   = CNT;
        len_d = W'(1);
        sat_d = 1'b0;
      end
      CNT: if (!in) begin
        m_d  = IDLE;
        done = 1'b1;
      end else if (&len_q) sat_d = 1'b1;
      else len_d = len_q + W'(1);
      default: m_d = ARM;
    endcase
  end
  // A release at the same edge as a completion frees the slot for that completion
  always_comb begin
    rel        = (o_q == OWAIT) && !rfd;
    load       = done && (!buf_full_q || rel);
    offer      = (o_q == OIDLE) && buf_full_q && rfd;
    buf_full_d = load | (buf_full_q & ~rel);
    buf_len_d  = load ? len_q : buf_len_q;
    buf_sat_d  = load ? sat_q : buf_sat_q;
    lost_d     = lost_q | (done & ~load);
    data_d     = offer ? buf_len_q : data_q;
    ovf_d      = offer ? buf_sat_q : ovf_q;
    o_d        = offer ? OWAIT : (rel ? OIDLE : o_q);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      m_q        <= ARM;
      o_q        <= OIDLE;
      len_q      <= '0;
      sat_q      <= 1'b0;
      buf_len_q  <= '0;
      buf_sat_q  <= 1'b0;
      buf_full_q <= 1'b0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      m_q        <= m_d;
      o_q        <= o_d;
      len_q      <= len_d;
      sat_q      <= sat_d;
      buf_len_q  <= buf_len_d;
      buf_sat_q  <= buf_sat_d;
      buf_full_q <= buf_full_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      lost_q     <= lost_d;
    end
  end
  assign data = data_q;
  assign ovf  = ovf_q;
  assign dav_ = (o_q != OWAIT);
  assign lost = lost_q;
endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: directed vectors with hand-computed expectations for pulse_meter
module tb_pulse_meter;
  logic       clock = 1'b0, reset = 1'b0, in = 1'b0, rfd = 1'b0;
  logic [7:0] data;
  logic       ovf, dav_, lost;
  int         n_chk = 0, n_ok = 0;
  pulse_meter #(.W(8)) dut (
    .clock(clock), .reset(reset), .in(in), .rfd(rfd),
    .data(data), .ovf(ovf), .dav_(dav_), .lost(lost)
  );
  always #5 clock = ~clock;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_ok++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic do_reset(input logic hold_in);
    reset = 1'b1;
    in    = hold_in;
    tick();
    reset = 1'b0;
  endtask
  task automatic pulse(input int n);
    in = 1'b1;
    tick(n);
    in = 1'b0;
    tick();
  endtask
  initial begin
    rfd = 1'b1;
    do_reset(1'b0);
    chk("rst_dav", dav_, 1);
    chk("rst_data", data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_lost", lost, 0);
    tick();
    pulse(5);
    chk("t1_no_same_cycle", dav_, 1);
    tick();
    chk("t1_dav", dav_, 0);
    chk("t1_data", data, 5);
    chk("t1_ovf", ovf, 0);
    rfd = 1'b0;
    tick();
    chk("t1_release", dav_, 1);
    rfd = 1'b1;
    do_reset(1'b0);
    tick();
    pulse(300);
    tick();
    chk("t2_dav", dav_, 0);
    chk("t2_data", data, 255);
    chk("t2_ovf", ovf, 1);
    rfd = 1'b0;
    tick();
    rfd = 1'b1;
    pulse(3);
    tick();
    chk("t2b_dav", dav_, 0);
    chk("t2b_data", data, 3);
    chk("t2b_ovf", ovf, 0);
    rfd = 1'b0;
    tick();
    rfd = 1'b1;
    do_reset(1'b1);
    tick(7);
    in = 1'b0;
    tick();
    chk("t3_armed_no_result", dav_, 1);
    pulse(4);
    tick();
    chk("t3_dav", dav_, 0);
    chk("t3_data", data, 4);
    rfd = 1'b0;
    tick();
    rfd = 1'b1;
    tick(3);
    chk("t3_single_result", dav_, 1);
    rfd = 1'b0;
    do_reset(1'b0);
    tick();
    pulse(2);
    tick();
    chk("t4_lost_first", lost, 0);
    pulse(3);
    chk("t4_lost_second", lost, 1);
    pulse(6);
    chk("t4_dav_held", dav_, 1);
    rfd = 1'b1;
    tick();
    chk("t4_dav", dav_, 0);
    chk("t4_data", data, 2);
    rfd = 1'b0;
    tick(2);
    chk("t4_empty", dav_, 1);
    chk("t4_lost_sticky", lost, 1);
    rfd = 1'b1;
    do_reset(1'b0);
    tick();
    in = 1'b1; tick();
    in = 1'b0; tick();
    in = 1'b1; tick();
    chk("t5_dav1", dav_, 0);
    chk("t5_data1", data, 1);
    in = 1'b0; rfd = 1'b0; tick();
    chk("t5_rel1", dav_, 1);
    in = 1'b1; rfd = 1'b1; tick();
    chk("t5_dav2", dav_, 0);
    chk("t5_data2", data, 1);
    in = 1'b0; rfd = 1'b0; tick();
    chk("t5_lost", lost, 0);
    rfd = 1'b1; tick();
    chk("t5_dav3", dav_, 0);
    chk("t5_data3", data, 1);
    rfd = 1'b0; tick();
    chk("t5_rel3", dav_, 1);
    rfd = 1'b1;
    do_reset(1'b0);
    tick();
    pulse(9);
    tick();
    chk("t6_dav", dav_, 0);
    chk("t6_data", data, 9);
    pulse(2);
    chk("t6_lost_set", lost, 1);
    in = 1'b1;
    tick(2);
    do_reset(1'b1);
    chk("t6_rst_dav", dav_, 1);
    chk("t6_rst_data", data, 0);
    chk("t6_rst_lost", lost, 0);
    tick(2);
    in = 1'b0;
    tick(4);
    chk("t6_inflight_dropped", dav_, 1);
    chk("t6_lost_clear", lost, 0);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
